// File: rtl/shreg_sequencer.sv
// Command-driven sequencer for the 4-bit shifting register: replays each accepted
// command as setup, N enabled cycles and a capture, and reports Q plus ones shifted out.
module shreg_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_modo,
    input  logic               i_cmd_dir,
    input  logic               i_cmd_sin,
    input  logic [3:0]         i_cmd_d,
    input  logic [COUNT_W-1:0] i_cmd_count,
    output logic               o_enb,
    output logic               o_dir,
    output logic               o_s_in,
    output logic [1:0]         o_modo,
    output logic [3:0]         o_d,
    input  logic [3:0]         i_q,
    input  logic               i_s_out,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [3:0]         o_result,
    output logic [COUNT_W:0]   o_ones
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0]       MODO_RESERVED = 2'b11;
    localparam logic [COUNT_W:0] ONES_MAX      = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic [COUNT_W-1:0] r_count;
    logic               r_enb;
    logic               r_dir;
    logic               r_s_in;
    logic [1:0]         r_modo;
    logic [3:0]         r_d;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [3:0]         r_result;
    logic [COUNT_W:0]   r_ones;

    assign w_accept = (r_state == S_IDLE) && i_cmd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if ((r_modo == MODO_RESERVED) || (r_count == '0)) begin
                    w_state_next = S_CAPTURE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == COUNT_W'(1)) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control pins are loaded at accept so they are already stable during SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_enb    <= 1'b0;
            r_dir    <= 1'b0;
            r_s_in   <= 1'b0;
            r_modo   <= 2'b10;
            r_d      <= 4'b0000;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 4'b0000;
            r_ones   <= '0;
        end else begin
            r_enb   <= (w_state_next == S_RUN);
            r_ready <= (w_state_next == S_IDLE);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dir   <= i_cmd_dir;
                        r_s_in  <= i_cmd_sin;
                        r_modo  <= i_cmd_modo;
                        r_d     <= i_cmd_d;
                        r_count <= i_cmd_count;
                        r_ones  <= '0;
                    end
                end
                S_RUN: begin
                    r_count <= r_count - 1'b1;
                    if (i_s_out && (r_ones != ONES_MAX)) begin
                        r_ones <= r_ones + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_result <= i_q;
                    r_done   <= 1'b1;
                    r_err    <= (r_modo == MODO_RESERVED);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_enb       = r_enb;
    assign o_dir       = r_dir;
    assign o_s_in      = r_s_in;
    assign o_modo      = r_modo;
    assign o_d         = r_d;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_result    = r_result;
    assign o_ones      = r_ones;

endmodule

// File: tb/tb_shreg_sequencer.sv
// Bench for shreg_sequencer: a 4-bit shift register plant closes the loop, and each
// command's result, ones count, enable length and timing are checked against a reference.
module tb_shreg_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_modo;
    logic          cmd_dir;
    logic          cmd_sin;
    logic [3:0]    cmd_d;
    logic [CW-1:0] cmd_count;
    logic          enb;
    logic          dir;
    logic          s_in;
    logic [1:0]    modo;
    logic [3:0]    d;
    logic [3:0]    plant_q = 4'b0000;
    logic          plant_s_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    result;
    logic [CW:0]   ones;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    shreg_sequencer #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_modo  (cmd_modo),
        .i_cmd_dir   (cmd_dir),
        .i_cmd_sin   (cmd_sin),
        .i_cmd_d     (cmd_d),
        .i_cmd_count (cmd_count),
        .o_enb       (enb),
        .o_dir       (dir),
        .o_s_in      (s_in),
        .o_modo      (modo),
        .o_d         (d),
        .i_q         (plant_q),
        .i_s_out     (plant_s_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_result    (result),
        .o_ones      (ones)
    );

    // Shift register plant: serial out is the bit leaving in the shift direction.
    assign plant_s_out = (modo == 2'b00 || modo == 2'b01) ? (dir ? plant_q[0] : plant_q[3]) : 1'b0;

    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b00: plant_q <= dir ? {s_in, plant_q[3:1]} : {plant_q[2:0], s_in};
                2'b01: plant_q <= dir ? {plant_q[0], plant_q[3:1]} : {plant_q[2:0], plant_q[3]};
                2'b10: plant_q <= d;
                default: plant_q <= plant_q;
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Functional reference: apply n operations arithmetically and count ones shifted out.
    function automatic void ref_cmd(input int q0, input int mode, input int dr, input int sn,
                                    input int dv, input int n, output int q_out, output int ones_out);
        int q;
        int bit_out;
        q = q0;
        ones_out = 0;
        if (mode == 3) n = 0;
        for (int i = 0; i < n; i++) begin
            if (mode == 2) begin
                q = dv;
            end else begin
                bit_out = dr ? (q & 1) : ((q >> 3) & 1);
                ones_out += bit_out;
                if (dr)
                    q = (q >> 1) | (((mode == 1) ? bit_out : sn) << 3);
                else
                    q = ((q << 1) | ((mode == 1) ? bit_out : sn)) & 15;
            end
        end
        q_out = q;
    endfunction

    task automatic check_reset(input string tag);
        check_val({tag, "_enb"},    enb,       0);
        check_val({tag, "_ready"},  cmd_ready, 1);
        check_val({tag, "_busy"},   busy,      0);
        check_val({tag, "_done"},   done,      0);
        check_val({tag, "_err"},    err,       0);
        check_val({tag, "_result"}, result,    0);
        check_val({tag, "_ones"},   ones,      0);
        check_val({tag, "_dir"},    dir,       0);
        check_val({tag, "_sin"},    s_in,      0);
        check_val({tag, "_modo"},   modo,      2);
        check_val({tag, "_d"},      d,         0);
    endtask

    // Presents one command, waits for DONE and checks everything; keep leaves CMD_VALID high.
    task automatic run_cmd(input int mode, input int dr, input int sn, input int dv, input int n, input bit keep);
        int exp_q;
        int exp_ones;
        int eff;
        int edges;
        int enb_cnt;
        int waits;
        bit got;
        @(negedge clk);
        waits = 0;
        while (!cmd_ready && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        check_val("ready_wait", cmd_ready, 1);
        cmd_modo  = mode[1:0];
        cmd_dir   = dr[0];
        cmd_sin   = sn[0];
        cmd_d     = dv[3:0];
        cmd_count = n[CW-1:0];
        cmd_valid = 1'b1;
        ref_cmd(int'(plant_q), mode, dr, sn, dv, n, exp_q, exp_ones);
        eff = (mode == 3) ? 0 : n;
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
        check_val("accept_busy",  busy,      1);
        check_val("accept_ready", cmd_ready, 0);
        check_val("done_clear",   done,      0);
        check_val("err_clear",    err,       0);
        edges = 0;
        enb_cnt = 0;
        got = 1'b0;
        while (!got && edges < eff + 8) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (enb) enb_cnt++;
                check_val("ready_in_busy", cmd_ready, 0);
            end
        end
        // DONE rises N+2 edges after the accept edge (N+3 counting the accept edge).
        check_val("done_seen",    got,       1);
        check_val("done_latency", edges,     eff + 2);
        check_val("enb_cycles",   enb_cnt,   eff);
        check_val("result",       result,    exp_q);
        check_val("ones",         ones,      exp_ones);
        check_val("err",          err,       (mode == 3) ? 1 : 0);
        check_val("ready_done",   cmd_ready, 1);
        check_val("busy_done",    busy,      0);
        check_val("enb_done",     enb,       0);
        check_val("modo_hold",    modo,      mode);
        check_val("dir_hold",     dir,       dr);
        check_val("d_hold",       d,         dv);
        $display("cmd mode=%0d dir=%0d sin=%0d d=%h n=%0d keep=%0d -> result=%h ones=%0d err=%0d latency=%0d",
                 mode, dr, sn, dv, n, keep, result, ones, err, edges);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_modo  = 2'b00;
        cmd_dir   = 1'b0;
        cmd_sin   = 1'b0;
        cmd_d     = 4'b0000;
        cmd_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(2, 0, 0, 4'b1000, 1, 1'b0);
        run_cmd(1, 0, 0, 0, 1, 1'b0);
        run_cmd(2, 0, 0, 4'b1000, 1, 1'b0);
        run_cmd(1, 0, 0, 0, 4, 1'b0);
        run_cmd(2, 0, 0, 4'b0000, 1, 1'b0);
        run_cmd(0, 0, 1, 0, 4, 1'b0);
        run_cmd(1, 1, 0, 4'b0101, 0, 1'b0);
        run_cmd(3, 1, 1, 4'b0110, 5, 1'b0);
        run_cmd(1, 1, 0, 0, 3, 1'b1);
        run_cmd(0, 0, 1, 0, 2, 1'b1);
        run_cmd(2, 0, 0, 4'b1011, 2, 1'b0);

        // Reset in the middle of a long circular shift.
        @(negedge clk);
        cmd_modo  = 2'b01;
        cmd_dir   = 1'b0;
        cmd_count = CW'(200);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("midrun_enb", enb, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midrun_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("reset_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(2, 0, 0, 4'b1000, 1, 1'b0);
        run_cmd(1, 0, 0, 0, 4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 12), ($urandom_range(0, 3) == 0));
        end
        run_cmd(1, 1, 0, 0, 5, 1'b0);

        @(posedge clk);
        #1;
        check_val("final_done_clear", done, 0);
        check_val("final_idle_ready", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
